// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the transmit-side byte buffer.
package uart_pkg;

    localparam int UART_DATA_WIDTH    = 8;
    localparam int UART_TX_FIFO_DEPTH = 16;
    localparam int UART_TX_FIFO_AFULL = 12;

    typedef logic [UART_DATA_WIDTH-1:0] uart_byte_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, full/empty, occupancy and overflow bookkeeping for a
// power-of-two FIFO. Holds no data, so it can be reused for an RX buffer.
module fifo_ptr_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH       = UART_TX_FIFO_DEPTH,
    parameter int AFULL_LEVEL = UART_TX_FIFO_AFULL
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    input  logic                       rd_ready,
    input  logic                       clear_overflow,
    output logic                       wr_en,
    output logic [$clog2(DEPTH)-1:0]   wr_idx,
    output logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_LEVEL);

    // The extra top bit on each pointer is the wrap bit that separates full from empty.
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_level;
    logic          r_overflow;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_en;
    logic          w_rd_en;

    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // Accept decisions look only at registered full/empty, never at the other side's strobe.
    assign w_wr_en = wr_valid && !w_full;
    assign w_rd_en = rd_ready && !w_empty;

    assign wr_en       = w_wr_en;
    assign wr_idx      = r_wr_ptr[AW-1:0];
    assign rd_idx      = r_rd_ptr[AW-1:0];
    assign full        = w_full;
    assign empty       = w_empty;
    assign level       = r_level;
    assign almost_full = (r_level >= AFULL_THR);
    assign overflow    = r_overflow;

    // Advance pointers on accepted transfers; reset discards everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Occupancy counter kept in step with the pointer difference.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
        end else begin
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + PW'(1);
                2'b01:   r_level <= r_level - PW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (wr_valid && w_full) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte buffer between the CPU's UART transmit
// strobe and the serialiser. Storage and the head mux live here; all
// bookkeeping lives in fifo_ptr_ctrl.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = UART_DATA_WIDTH,
    parameter int DEPTH       = UART_TX_FIFO_DEPTH,
    parameter int AFULL_LEVEL = UART_TX_FIFO_AFULL
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     clear_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_wr_en;
    logic [AW-1:0]         w_wr_idx;
    logic [AW-1:0]         w_rd_idx;
    logic                  w_full;
    logic                  w_empty;

    fifo_ptr_ctrl #(
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (AFULL_LEVEL)
    ) u_ptr (
        .clk            (clk),
        .reset          (reset),
        .wr_valid       (wr_valid),
        .rd_ready       (rd_ready),
        .clear_overflow (clear_overflow),
        .wr_en          (w_wr_en),
        .wr_idx         (w_wr_idx),
        .rd_idx         (w_rd_idx),
        .full           (w_full),
        .empty          (w_empty),
        .level          (level),
        .almost_full    (almost_full),
        .overflow       (overflow)
    );

    // Store accepted bytes; a write presented during reset is discarded.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) begin
            r_mem[w_wr_idx] <= wr_data;
        end
    end

    // Head byte falls straight through from the array; zero when empty.
    assign rd_data  = w_empty ? '0 : r_mem[w_rd_idx];
    assign rd_valid = !w_empty;
    assign wr_ready = !w_full;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO between the CPU core's UART transmit outputs and the UART interface's transmit inputs. It absorbs bursts of CPU-written bytes while the UART serialises at `BAUD_RATE`, so the core never has to wait on the serial link. Full and overflow conditions are reported to the CPU debug/status path. The read side uses a first-word-fall-through valid/ready handshake.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: byte width; matches the UART data width.
- `DEPTH`, default 16: number of entries; must be a power of two and ≥ 2.
- `AFULL_LEVEL`, default 12: `almost_full` asserts when `level` ≥ this value; range 1..`DEPTH`.

Ports:
- `clk`, in, 1: system clock; the single clock domain.
- `reset`, in, 1: synchronous reset, active-high.
- `wr_data`, in, `DATA_WIDTH`: byte from the CPU core (`uart_tx_data`).
- `wr_valid`, in, 1: write strobe from the CPU core (`uart_tx_valid`).
- `wr_ready`, out, 1: space available; equals `!full`.
- `rd_data`, out, `DATA_WIDTH`: head byte to the UART interface (`tx_data_in`).
- `rd_valid`, out, 1: FIFO non-empty (`tx_valid_in`).
- `rd_ready`, in, 1: UART accepts the head byte.
- `level`, out, `$clog2(DEPTH)+1`: current occupancy, 0..`DEPTH`.
- `almost_full`, out, 1: `level` ≥ `AFULL_LEVEL`.
- `overflow`, out, 1: sticky flag; a write was dropped because the FIFO was full.
- `clear_overflow`, in, 1: clears `overflow` for one cycle.

## Operation
- Storage: `DEPTH` × `DATA_WIDTH` register array. Storage is not reset.
- Pointers: `wr_ptr` and `rd_ptr`, each `$clog2(DEPTH)+1` bits, including a wrap bit. They increment modulo 2·`DEPTH`.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
- Write accept: `wr_valid && !full`. On accept, the array entry at `wr_ptr[idx]` takes `wr_data` and `wr_ptr` increments.
- Dropped write: `wr_valid && full`. No state change except `overflow` ← 1. This applies even if a read happens in the same cycle; `wr_ready` never depends on `rd_ready`.
- Read accept: `rd_valid && rd_ready`. On accept, `rd_ptr` increments. `rd_ready` while empty is ignored.
- `rd_data` = array[`rd_ptr[idx]`] when non-empty, and 0 when empty. It is a combinational mux from registers, with no extra output register.
- `level` is a registered counter:
  - +1 on write-only accept.
  - −1 on read-only accept.
  - Unchanged when both accept or neither does.
  - It must always equal `wr_ptr − rd_ptr`.
- `overflow` priority: set beats clear. A dropped write in the same cycle as `clear_overflow` leaves `overflow` = 1.
- Simultaneous read and write at `level` = 1 is legal. The head is consumed, the new byte is stored, and `level` stays at 1.
- When empty, a write and `rd_ready` in the same cycle produce no read, because `rd_valid` was 0.

## Timing
- Reset values: `wr_ready`=1, `rd_valid`=0, `rd_data`=0, `level`=0, `almost_full`=0, `overflow`=0. Both pointers are 0.
- Reset mid-operation discards all contents. Outputs return to their reset values on the cycle after `reset` is sampled high. Any write or read presented in the reset cycle is ignored.
- Write-to-read latency is 1 cycle. A byte accepted at edge N drives `rd_valid`=1 and `rd_data` from edge N onward, so the UART can accept it in cycle N+1.
- `wr_ready`, `rd_valid`, `level`, `almost_full` and `overflow` are all derived from registers; there are no combinational paths from `wr_valid` or `rd_ready`.
- Sustained throughput is one write and one read per cycle.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_WIDTH` = 8.
  - `UART_TX_FIFO_DEPTH` = 16.
  - `UART_TX_FIFO_AFULL` = 12.
  - The `uart_byte_t` typedef.
- Sub-module `fifo_ptr_ctrl`: pointer, full/empty, and level logic, reusable for a later RX-side buffer.
- Storage array and output mux remain in `uart_tx_fifo`.
- Assertions in the bench:
  - `level` == `wr_ptr` − `rd_ptr`.
  - Never full and empty at once.

## Test plan
- Reset, then write 0x41, 0x42, 0x43 on consecutive cycles with `rd_ready`=0. Required: `level`=3, `rd_data`=0x41, `rd_valid`=1. Then hold `rd_ready`=1 for 3 cycles. Required: reads 0x41, 0x42, 0x43 in order, then `rd_valid`=0 and `rd_data`=0.
- Fill 16 bytes (0x00..0x0F). Required: `almost_full` rises when `level`=12; at `level`=16, `wr_ready`=0. Then write 0xFF. Required: `overflow`=1, `level` stays 16, and a full drain yields 0x00..0x0F with no 0xFF.
- With the FIFO full, assert `wr_valid` (data 0xAA) and `rd_ready` together. Required: head popped, 0xAA dropped, `level`=15, `overflow`=1. Then pulse `clear_overflow` alone. Required: `overflow`=0 next cycle.
- Stream 40 bytes with `wr_valid` and `rd_ready` held high continuously (pointers wrap twice). Required: output sequence equals input sequence, `level` never exceeds 1, and no overflow.
- Write 5 bytes, assert `reset` for 1 cycle during a simultaneous read/write. Required: next cycle `level`=0, `rd_valid`=0, `wr_ready`=1, `overflow`=0. A subsequent write of 0x55 then reads back 0x55 first.
